// File: rtl/cf_fft_1024_8_bfly.sv
// Radix-2 DIF single-delay-feedback butterfly: first half is buffered, second half yields
// sums immediately and twiddled differences that are replayed during the next first half.
`timescale 1ns/1ps
module cf_fft_1024_8_bfly #(
    parameter int N_LOG2 = 8
) (
    input  logic              clock_c,
    input  logic              reset,
    input  logic              enable,
    input  logic              start_i,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic [N_LOG2-2:0] tw_addr,
    input  logic [31:0]       tw_data,
    output logic              out_start,
    output logic              out_we,
    output logic [N_LOG2-1:0] out_addr,
    output logic [31:0]       out_data
);

    localparam int HALF = 1 << (N_LOG2 - 1);

    function automatic logic signed [15:0] halve(input logic signed [16:0] v);
        return 16'(v >>> 1);
    endfunction

    function automatic logic signed [15:0] round_sat(input logic signed [33:0] v);
        logic signed [33:0] r;
        r = (v + 34'sd16384) >>> 15;
        if (r > 34'sd32767)
            return 16'sh7fff;
        else if (r < -34'sd32768)
            return 16'sh8000;
        else
            return 16'(r);
    endfunction

    logic [N_LOG2-1:0] count;
    logic              diff_pend;
    logic [31:0]       delay_ram [HALF];
    logic [31:0]       diff_ram  [HALF];

    // stage p0: sample acceptance, index resolution, RAM reads
    logic              accept;
    logic              restart;
    logic [N_LOG2-1:0] idx_p0;
    logic              second_p0;
    logic [N_LOG2-2:0] k_p0;
    logic              pend_p0;

    assign accept    = enable & in_valid;
    assign restart   = start_i & (count != '0);
    assign idx_p0    = start_i ? '0 : count;
    assign second_p0 = idx_p0[N_LOG2-1];
    assign k_p0      = idx_p0[N_LOG2-2:0];
    // a mid-frame restart discards whatever differences were still waiting
    assign pend_p0   = diff_pend & ~restart;
    assign tw_addr   = count[N_LOG2-2:0];

    logic              vld_p1;
    logic              second_p1;
    logic [N_LOG2-2:0] k_p1;
    logic [31:0]       a_p1;
    logic [31:0]       b_p1;
    logic [31:0]       diff_rd_p1;

    always_ff @(posedge clock_c) begin
        if (accept && !second_p0)
            delay_ram[k_p0] <= in_data;
    end

    always_ff @(posedge clock_c) begin
        if (enable) begin
            second_p1  <= second_p0;
            k_p1       <= k_p0;
            b_p1       <= in_data;
            a_p1       <= delay_ram[k_p0];
            diff_rd_p1 <= diff_ram[k_p0];
        end
    end

    // stage p1: butterfly and twiddle multiply, tw_data now aligned with k_p1
    logic signed [15:0] ar_p1, ai_p1, br_p1, bi_p1, wr_p1, wi_p1;
    logic signed [15:0] sr_p1, si_p1, dr_p1, di_p1;
    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [15:0] mr_p1, mi_p1;

    assign ar_p1 = $signed(a_p1[31:16]);
    assign ai_p1 = $signed(a_p1[15:0]);
    assign br_p1 = $signed(b_p1[31:16]);
    assign bi_p1 = $signed(b_p1[15:0]);
    assign wr_p1 = $signed(tw_data[31:16]);
    assign wi_p1 = $signed(tw_data[15:0]);

    assign sr_p1 = halve($signed({ar_p1[15], ar_p1}) + $signed({br_p1[15], br_p1}));
    assign si_p1 = halve($signed({ai_p1[15], ai_p1}) + $signed({bi_p1[15], bi_p1}));
    assign dr_p1 = halve($signed({ar_p1[15], ar_p1}) - $signed({br_p1[15], br_p1}));
    assign di_p1 = halve($signed({ai_p1[15], ai_p1}) - $signed({bi_p1[15], bi_p1}));

    assign p_rr = 32'(dr_p1) * 32'(wr_p1);
    assign p_ii = 32'(di_p1) * 32'(wi_p1);
    assign p_ri = 32'(dr_p1) * 32'(wi_p1);
    assign p_ir = 32'(di_p1) * 32'(wr_p1);

    assign mr_p1 = round_sat(34'(p_rr) - 34'(p_ii));
    assign mi_p1 = round_sat(34'(p_ri) + 34'(p_ir));

    always_ff @(posedge clock_c) begin
        if (enable && vld_p1 && second_p1)
            diff_ram[k_p1] <= {mr_p1, mi_p1};
    end

    // stage p2: registered write port towards the reorder buffer
    always_ff @(posedge clock_c) begin
        if (reset) begin
            count     <= '0;
            diff_pend <= 1'b0;
            vld_p1    <= 1'b0;
            out_start <= 1'b0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (enable) begin
            vld_p1 <= in_valid & (second_p0 | pend_p0);
            if (in_valid) begin
                count <= idx_p0 + 1'b1;
                if (restart)
                    diff_pend <= 1'b0;
                else if (&idx_p0)
                    diff_pend <= 1'b1;
                else if (idx_p0 == N_LOG2'(HALF - 1))
                    diff_pend <= 1'b0;
            end
            out_we    <= vld_p1;
            out_start <= vld_p1 & second_p1 & (k_p1 == '0);
            out_addr  <= {~second_p1, k_p1};
            out_data  <= second_p1 ? {sr_p1, si_p1} : diff_rd_p1;
        end
    end

endmodule

// File: tb/tb_cf_fft_1024_8_bfly.sv
// Bench for cf_fft_1024_8_bfly: a frame-level reference predicts every buffer write and the
// cycle it must appear; directed frames pin DC, impulse, saturation, stall, restart and reset.
`timescale 1ns/1ps
module tb_cf_fft_1024_8_bfly;

    logic        clock_c = 1'b0;
    logic        reset, enable, start_i, in_valid;
    logic [31:0] in_data;
    logic [6:0]  tw_addr;
    logic [31:0] tw_data;
    logic        out_start, out_we;
    logic [7:0]  out_addr;
    logic [31:0] out_data;

    cf_fft_1024_8_bfly #(.N_LOG2(8)) dut (
        .clock_c(clock_c), .reset(reset), .enable(enable), .start_i(start_i),
        .in_valid(in_valid), .in_data(in_data), .tw_addr(tw_addr), .tw_data(tw_data),
        .out_start(out_start), .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clock_c = ~clock_c;

    logic [31:0] tw_tab [128];
    logic [31:0] frame  [256];

    // twiddle ROM with one enabled cycle of read latency
    always @(posedge clock_c) if (enable) tw_data <= tw_tab[tw_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at time %0t", nm, act, req, $time);
        end
    endtask

    function automatic int hi(input logic [31:0] w);
        return int'($signed(w[31:16]));
    endfunction
    function automatic int lo(input logic [31:0] w);
        return int'($signed(w[15:0]));
    endfunction
    function automatic logic [31:0] pack(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction
    function automatic int rsat(input longint v);
        longint r;
        r = (v + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    typedef struct {
        int          due;
        bit          st;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    int          mcount = 0;
    bit          mpend  = 1'b0;
    logic [31:0] mdelay [128];
    logic [31:0] mdiff  [128];
    int          ecyc   = 0;
    bit          fresh  = 1'b0;
    bit          exp_we = 1'b0, exp_st = 1'b0, exp_zero = 1'b1;
    logic [7:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;

    // frame-level reference: what each accepted sample must cause, one enabled cycle later
    task automatic model_accept();
        int idx, k, ar, ai, br, bi, dr, di, wr, wi;
        longint pr, pim;
        wr_t e;
        idx = start_i ? 0 : mcount;
        if (start_i && mcount != 0) mpend = 1'b0;
        e.due = ecyc + 1;
        e.st  = 1'b0;
        if (idx < 128) begin
            mdelay[idx] = in_data;
            if (mpend) begin
                e.addr = 8'(128 + idx);
                e.data = mdiff[idx];
                q.push_back(e);
            end
            if (idx == 127) mpend = 1'b0;
        end else begin
            k  = idx - 128;
            ar = hi(mdelay[k]); ai = lo(mdelay[k]);
            br = hi(in_data);   bi = lo(in_data);
            e.addr = 8'(k);
            e.st   = (k == 0);
            e.data = pack((ar + br) >>> 1, (ai + bi) >>> 1);
            q.push_back(e);
            dr = (ar - br) >>> 1;
            di = (ai - bi) >>> 1;
            wr = hi(tw_tab[k]);
            wi = lo(tw_tab[k]);
            pr  = longint'(dr) * wr - longint'(di) * wi;
            pim = longint'(dr) * wi + longint'(di) * wr;
            mdiff[k] = pack(rsat(pr), rsat(pim));
            if (idx == 255) mpend = 1'b1;
        end
        mcount = (idx + 1) % 256;
    endtask

    always @(posedge clock_c) begin
        wr_t e;
        if (reset) begin
            mcount = 0; mpend = 1'b0; q.delete();
            exp_we = 1'b0; exp_st = 1'b0; exp_addr = '0; exp_data = '0; exp_zero = 1'b1;
            fresh = 1'b0;
        end else if (enable) begin
            ecyc++;
            fresh = 1'b1;
            exp_zero = 1'b0;
            if (in_valid) model_accept();
            if (q.size() > 0 && q[0].due == ecyc) begin
                e = q.pop_front();
                exp_we = 1'b1; exp_st = e.st; exp_addr = e.addr; exp_data = e.data;
            end else begin
                exp_we = 1'b0; exp_st = 1'b0;
            end
        end else begin
            fresh = 1'b0;
        end
    end

    logic [31:0] cap    [256];
    bit          cap_st [256];
    int          last_diff = -1;
    int          diff_cnt  = 0;
    int          sum_cnt   = 0;

    // single compare process: outputs checked on every cycle against the reference
    always @(negedge clock_c) begin
        chk("we", 32'(out_we), 32'(exp_we));
        chk("start", 32'(out_start), 32'(exp_st));
        if (exp_we || exp_zero) begin
            chk("addr", 32'(out_addr), 32'(exp_addr));
            chk("data", out_data, exp_data);
        end
        if (fresh && out_we === 1'b1) begin
            cap[out_addr]    = out_data;
            cap_st[out_addr] = out_start;
            if (out_addr >= 8'd128) begin
                last_diff = int'(out_addr);
                diff_cnt++;
            end else begin
                sum_cnt++;
            end
        end
    end

    task automatic clear_cap();
        for (int i = 0; i < 256; i++) begin
            cap[i] = 32'hdead_beef;
            cap_st[i] = 1'b0;
        end
        last_diff = -1;
        diff_cnt  = 0;
        sum_cnt   = 0;
    endtask

    task automatic cyc(input bit en, input bit vld, input bit st, input logic [31:0] d);
        enable = en; in_valid = vld; start_i = st; in_data = d;
        @(posedge clock_c);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic send(input int from, input int to, input bit st_first, input bit gaps);
        for (int i = from; i <= to; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0)
                    cyc(1'($urandom_range(0, 1)) & 1'b0 | 1'($urandom_range(0, 1)),
                        1'b0, 1'($urandom_range(0, 1)), $urandom);
                if ($urandom_range(0, 3) == 0)
                    cyc(1'b0, 1'b1, 1'b0, $urandom);
            end
            cyc(1'b1, 1'b1, st_first && (i == from), frame[i]);
        end
        enable = 1'b1; in_valid = 1'b0; start_i = 1'b0;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 256; i++) frame[i] = v;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; start_i = 1'b0; in_data = '0;
        for (int i = 0; i < 128; i++) tw_tab[i] = 32'h7fff_0000;
        clear_cap();
        repeat (3) @(posedge clock_c);
        #1;
        chk("reset_we", 32'(out_we), 32'h0);
        chk("reset_data", out_data, 32'h0);
        reset = 1'b0;

        // DC frame, then its (zero) differences during the next frame's first half
        fill(32'h4000_0000);
        send(0, 255, 1'b1, 1'b0);
        idle(3);
        chk("dc_sum0", cap[0], 32'h4000_0000);
        chk("dc_start0", 32'(cap_st[0]), 32'h1);
        chk("dc_sum127", cap[127], 32'h4000_0000);
        chk("dc_start5", 32'(cap_st[5]), 32'h0);
        clear_cap();
        send(0, 127, 1'b1, 1'b0);
        idle(3);
        chk("dc_diff128", cap[128], 32'h0);
        chk("dc_diff255", cap[255], 32'h0);
        send(128, 255, 1'b0, 1'b0);

        // impulse
        fill(32'h0);
        frame[0] = 32'h2000_0000;
        clear_cap();
        send(0, 255, 1'b1, 1'b0);
        idle(3);
        chk("imp_sum0", cap[0], 32'h1000_0000);
        chk("imp_sum1", cap[1], 32'h0);
        fill(32'h0);
        clear_cap();
        send(0, 127, 1'b1, 1'b0);
        idle(3);
        chk("imp_diff128", cap[128], 32'h1000_0000);
        chk("imp_diff129", cap[129], 32'h0);
        send(128, 255, 1'b0, 1'b0);

        // saturating twiddle product
        tw_tab[3] = 32'h8000_0000;
        fill(32'h0);
        frame[3]   = 32'h8000_0000;
        frame[131] = 32'h7fff_0000;
        send(0, 255, 1'b1, 1'b0);
        idle(2);
        tw_tab[3] = 32'h7fff_0000;
        fill(32'h0);
        clear_cap();
        send(0, 127, 1'b1, 1'b0);
        idle(3);
        chk("sat_diff131", cap[131], 32'h7fff_0000);
        send(128, 255, 1'b0, 1'b0);

        // random data and twiddles with enable and valid gaps
        for (int i = 0; i < 128; i++) tw_tab[i] = $urandom;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 256; i++) frame[i] = $urandom;
            send(0, 255, 1'b1, 1'b1);
        end
        idle(3);

        // restart at index 60 of a first half while differences are pending
        for (int i = 0; i < 256; i++) frame[i] = $urandom;
        clear_cap();
        send(0, 59, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) frame[i] = $urandom;
        send(0, 127, 1'b1, 1'b0);
        idle(3);
        chk("mid_last_diff", 32'(last_diff), 32'd187);
        chk("mid_diff_cnt", 32'(diff_cnt), 32'd60);
        send(128, 255, 1'b0, 1'b1);
        idle(3);
        chk("mid_sum_cnt", 32'(sum_cnt), 32'd128);

        // reset in the middle of a second half
        for (int i = 0; i < 256; i++) frame[i] = $urandom;
        send(0, 177, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, frame[178]);
        reset = 1'b0;
        @(negedge clock_c);
        chk("rst_mid_we", 32'(out_we), 32'h0);
        chk("rst_mid_start", 32'(out_start), 32'h0);
        chk("rst_mid_addr", 32'(out_addr), 32'h0);
        chk("rst_mid_data", out_data, 32'h0);
        @(posedge clock_c);
        #1;
        clear_cap();
        for (int i = 0; i < 256; i++) frame[i] = $urandom;
        send(0, 255, 1'b1, 1'b0);
        idle(4);
        chk("rst_no_diff", 32'(diff_cnt), 32'd0);
        chk("rst_sum_cnt", 32'(sum_cnt), 32'd128);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
